// File: rtl/sound_mix_pkg.sv
// Shared types for the sound mixer: FSM states, per-channel gain record and its reset value.
package sound_mix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_OUT
  } mix_state_t;

  // Gain multiplier field is sized for the widest supported MUL_WIDTH; writes zero-extend.
  localparam int GAIN_MUL_W = 8;

  typedef struct packed {
    logic [GAIN_MUL_W-1:0] mul;
    logic [2:0]            shift;
    logic                  mute;
  } gain_t;

  localparam logic [GAIN_MUL_W-1:0] GAIN_RESET_MUL   = 8'd1;
  localparam logic [2:0]            GAIN_RESET_SHIFT = 3'd0;
  localparam logic                  GAIN_RESET_MUTE  = 1'b0;
  localparam gain_t GAIN_RESET = '{mul: GAIN_RESET_MUL, shift: GAIN_RESET_SHIFT, mute: GAIN_RESET_MUTE};

endpackage

// File: rtl/sound_mix_term.sv
// One gained channel term: (sample * mul) >>> shift, forced to zero when muted.
// Latency: combinational. Backpressure: none.
module sound_mix_term
  import sound_mix_pkg::*;
#(
  parameter int BIT_WIDTH = 10,
  parameter int MUL_WIDTH = 4
) (
  input  logic signed [BIT_WIDTH-1:0]       sample,
  input  logic        [GAIN_MUL_W-1:0]      mul,
  input  logic        [2:0]                 shift,
  input  logic                              mute,
  output logic signed [BIT_WIDTH+MUL_WIDTH:0] term
);

  localparam int PW     = BIT_WIDTH + GAIN_MUL_W + 1;
  localparam int TERM_W = BIT_WIDTH + MUL_WIDTH + 1;

  logic signed [PW-1:0] s_ext;
  logic signed [PW-1:0] m_ext;

  // mul is unsigned, so it is zero-extended before entering the signed product
  always_comb begin
    s_ext = PW'(sample);
    m_ext = $signed(PW'(mul));
    term  = '0;
    if (!mute) begin
      term = TERM_W'((s_ext * m_ext) >>> shift);
    end
  end

endmodule

// File: rtl/sound_mixer_att.sv
// Sequential N-channel mixer with per-channel attenuation; SOUND_MIXER_SAT_EN saturates MIX_OUT.
// Latency: SAMPLE_STB to MIX_VALID is CHANNELS+2 cycles. Backpressure: strobes while BUSY are dropped and flag OVERRUN.
module sound_mixer_att
  import sound_mix_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int BIT_WIDTH = 10,
  parameter int OUT_WIDTH = 16,
  parameter int MUL_WIDTH = 4
) (
  input  logic                            CLK,
  input  logic                            RESET_n,
  input  logic                            SAMPLE_STB,
  input  logic [CHANNELS*BIT_WIDTH-1:0]   SAMPLE_IN,
  input  logic                            CFG_WR,
  input  logic [2:0]                      CFG_CH,
  input  logic [MUL_WIDTH-1:0]            CFG_MUL,
  input  logic [2:0]                      CFG_SHIFT,
  input  logic                            CFG_MUTE,
  output logic signed [OUT_WIDTH-1:0]     MIX_OUT,
  output logic                            MIX_VALID,
  output logic                            BUSY,
  output logic                            OVERRUN
);

  localparam int ACC_W  = BIT_WIDTH + MUL_WIDTH + 4;
  localparam int TERM_W = BIT_WIDTH + MUL_WIDTH + 1;

  mix_state_t                    state;
  logic [2:0]                    ch_idx;
  logic [CHANNELS*BIT_WIDTH-1:0] sample_q;
  gain_t                         gain_q [CHANNELS];
  gain_t                         gain0_q;
  logic signed [ACC_W-1:0]       acc_q;

  logic signed [BIT_WIDTH-1:0]   cur_sample;
  gain_t                         cur_gain;
  logic signed [TERM_W-1:0]      term;
  logic signed [OUT_WIDTH-1:0]   acc_out;

  // Channel 0 uses the gain captured with the strobe, so a same-cycle write to it applies to the next mix.
  always_comb begin
    cur_sample = '0;
    cur_gain   = gain0_q;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ch_idx == 3'(k)) begin
        cur_sample = sample_q[k*BIT_WIDTH +: BIT_WIDTH];
        if (k != 0) begin
          cur_gain = gain_q[k];
        end
      end
    end
  end

  sound_mix_term #(
    .BIT_WIDTH(BIT_WIDTH),
    .MUL_WIDTH(MUL_WIDTH)
  ) u_term (
    .sample(cur_sample),
    .mul   (cur_gain.mul),
    .shift (cur_gain.shift),
    .mute  (cur_gain.mute),
    .term  (term)
  );

  generate
`ifdef SOUND_MIXER_SAT_EN
    if (OUT_WIDTH < ACC_W) begin : g_sat
      localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
      localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
      always_comb begin
        acc_out = OUT_WIDTH'(acc_q);
        if (acc_q > MAX_V) begin
          acc_out = OUT_WIDTH'(MAX_V);
        end else if (acc_q < MIN_V) begin
          acc_out = OUT_WIDTH'(MIN_V);
        end
      end
    end else begin : g_ext
      assign acc_out = OUT_WIDTH'(acc_q);
    end
`else
    begin : g_wrap
      assign acc_out = OUT_WIDTH'(acc_q);
    end
`endif
  endgenerate

  // Writes to channels outside 0..CHANNELS-1 match no register and are dropped.
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      for (int k = 0; k < CHANNELS; k++) begin
        gain_q[k] <= GAIN_RESET;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (CFG_WR && CFG_CH == 3'(k)) begin
          gain_q[k] <= '{mul: GAIN_MUL_W'(CFG_MUL), shift: CFG_SHIFT, mute: CFG_MUTE};
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state     <= ST_IDLE;
      ch_idx    <= '0;
      sample_q  <= '0;
      gain0_q   <= GAIN_RESET;
      acc_q     <= '0;
      MIX_OUT   <= '0;
      MIX_VALID <= 1'b0;
      BUSY      <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      MIX_VALID <= 1'b0;
      if (SAMPLE_STB && state != ST_IDLE) begin
        OVERRUN <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (SAMPLE_STB) begin
            sample_q <= SAMPLE_IN;
            gain0_q  <= gain_q[0];
            acc_q    <= '0;
            ch_idx   <= '0;
            BUSY     <= 1'b1;
            state    <= ST_ACC;
          end
        end
        ST_ACC: begin
          acc_q <= acc_q + ACC_W'(term);
          if (ch_idx == 3'(CHANNELS-1)) begin
            state <= ST_OUT;
          end else begin
            ch_idx <= ch_idx + 3'd1;
          end
        end
        ST_OUT: begin
          MIX_OUT   <= acc_out;
          MIX_VALID <= 1'b1;
          BUSY      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sound_mixer_att.sv
// Directed bench for sound_mixer_att: a vector table plus hand sequences for overrun, config timing, saturation and reset.
module tb_sound_mixer_att;

  logic               clk = 1'b0;
  logic               RESET_n = 1'b0;
  logic               SAMPLE_STB = 1'b0;
  logic [39:0]        SAMPLE_IN = '0;
  logic               CFG_WR = 1'b0;
  logic [2:0]         CFG_CH = '0;
  logic [3:0]         CFG_MUL = '0;
  logic [2:0]         CFG_SHIFT = '0;
  logic               CFG_MUTE = 1'b0;
  logic signed [15:0] MIX_OUT;
  logic               MIX_VALID, BUSY, OVERRUN;
  logic signed [9:0]  MIX_OUT10;
  logic               MIX_VALID10, BUSY10, OVERRUN10;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sound_mixer_att dut (
    .CLK(clk), .RESET_n(RESET_n), .SAMPLE_STB(SAMPLE_STB), .SAMPLE_IN(SAMPLE_IN),
    .CFG_WR(CFG_WR), .CFG_CH(CFG_CH), .CFG_MUL(CFG_MUL), .CFG_SHIFT(CFG_SHIFT), .CFG_MUTE(CFG_MUTE),
    .MIX_OUT(MIX_OUT), .MIX_VALID(MIX_VALID), .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  sound_mixer_att #(.OUT_WIDTH(10)) dut_w10 (
    .CLK(clk), .RESET_n(RESET_n), .SAMPLE_STB(SAMPLE_STB), .SAMPLE_IN(SAMPLE_IN),
    .CFG_WR(CFG_WR), .CFG_CH(CFG_CH), .CFG_MUL(CFG_MUL), .CFG_SHIFT(CFG_SHIFT), .CFG_MUTE(CFG_MUTE),
    .MIX_OUT(MIX_OUT10), .MIX_VALID(MIX_VALID10), .BUSY(BUSY10), .OVERRUN(OVERRUN10)
  );

  typedef struct {
    int cfg_ch;  // -1: no config write before this mix
    int mul;
    int sh;
    int mute;
    int s0, s1, s2, s3;
    int exp;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] pack4(input int a, input int b, input int c, input int d);
    logic [39:0] v;
    v[9:0]   = 10'(a);
    v[19:10] = 10'(b);
    v[29:20] = 10'(c);
    v[39:30] = 10'(d);
    return v;
  endfunction

  task automatic cfg(input int ch, input int mul, input int sh, input int mute);
    CFG_WR = 1'b1; CFG_CH = 3'(ch); CFG_MUL = 4'(mul); CFG_SHIFT = 3'(sh); CFG_MUTE = 1'(mute);
    tick;
    CFG_WR = 1'b0;
  endtask

  // Strobe one mix (optionally with a same-cycle config write) and wait, bounded, for MIX_VALID.
  task automatic run_mix(input logic [39:0] smp, input bit with_cfg, input int ch, input int mul,
                         output int lat, output int res, output int res10);
    SAMPLE_IN = smp;
    SAMPLE_STB = 1'b1;
    if (with_cfg) begin
      CFG_WR = 1'b1; CFG_CH = 3'(ch); CFG_MUL = 4'(mul); CFG_SHIFT = 3'd0; CFG_MUTE = 1'b0;
    end
    tick;
    SAMPLE_STB = 1'b0;
    CFG_WR = 1'b0;
    lat = 1;
    while (!MIX_VALID && lat < 20) begin
      tick;
      lat++;
    end
    res = int'(MIX_OUT);
    res10 = int'(MIX_OUT10);
  endtask

  initial begin
    vec_t tbl[9];
    int lat, res, res10, nv, last;

    tbl[0] = '{-1, 0, 0, 0,  100, -50,  20,   0,  70};
    tbl[1] = '{ 0, 9, 2, 0,  100,   0,   0,   0, 225};
    tbl[2] = '{-1, 0, 0, 0,   -3,   0,   0,   0,  -7};
    tbl[3] = '{ 0, 1, 0, 0, -512, 511,   0,   1,   0};
    tbl[4] = '{ 1, 1, 0, 1,   10, 500,  10,  10,  30};
    tbl[5] = '{ 1, 1, 0, 0,   10, 500,  10,  10, 530};
    tbl[6] = '{ 3, 3, 1, 0,    0,   0,   0,  -7, -11};
    tbl[7] = '{ 4, 0, 0, 1,    1,   2,   3,   4,  12};
    tbl[8] = '{ 3, 1, 0, 0,   -1,  -1,  -1,  -1,  -4};

    tick; tick;
    RESET_n = 1'b1;
    chk("reset_mix_out", int'(MIX_OUT), 0);
    chk("reset_mix_valid", int'(MIX_VALID), 0);
    chk("reset_busy", int'(BUSY), 0);
    chk("reset_overrun", int'(OVERRUN), 0);

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].cfg_ch >= 0) cfg(tbl[i].cfg_ch, tbl[i].mul, tbl[i].sh, tbl[i].mute);
      run_mix(pack4(tbl[i].s0, tbl[i].s1, tbl[i].s2, tbl[i].s3), 1'b0, 0, 0, lat, res, res10);
      chk($sformatf("vec%0d_latency", i), lat, 6);
      chk($sformatf("vec%0d_mix_out", i), res, tbl[i].exp);
    end

    // Second strobe two cycles into a mix is dropped and sets the sticky flag.
    SAMPLE_IN = pack4(1, 1, 1, 1); SAMPLE_STB = 1'b1; tick;
    SAMPLE_STB = 1'b0; chk("busy_in_acc", int'(BUSY), 1); tick;
    SAMPLE_IN = pack4(50, 50, 50, 50); SAMPLE_STB = 1'b1; tick;
    SAMPLE_STB = 1'b0;
    nv = 0; last = -999;
    for (int c = 0; c < 12; c++) begin
      if (MIX_VALID) begin nv++; last = int'(MIX_OUT); end
      tick;
    end
    chk("overrun_valid_count", nv, 1);
    chk("overrun_mix_out", last, 4);
    chk("overrun_flag", int'(OVERRUN), 1);
    chk("hold_mix_out", int'(MIX_OUT), 4);
    chk("hold_mix_valid", int'(MIX_VALID), 0);

    // Same-cycle write: channel 0 keeps its old gain for this mix, other channels take the new one.
    run_mix(pack4(100, 0, 0, 0), 1'b1, 0, 2, lat, res, res10);
    chk("samecyc_ch0_old_gain", res, 100);
    run_mix(pack4(100, 0, 0, 0), 1'b0, 0, 0, lat, res, res10);
    chk("samecyc_ch0_next_mix", res, 200);
    run_mix(pack4(0, 50, 0, 0), 1'b1, 1, 2, lat, res, res10);
    chk("samecyc_ch1_new_gain", res, 100);

    // Writes during ACC: ch2 change lands before ch2 is summed, ch0 change lands too late.
    SAMPLE_IN = pack4(10, 10, 10, 10); SAMPLE_STB = 1'b1; tick;
    SAMPLE_STB = 1'b0;
    CFG_WR = 1'b1; CFG_CH = 3'd2; CFG_MUL = 4'd4; CFG_SHIFT = 3'd0; CFG_MUTE = 1'b0; tick;
    CFG_CH = 3'd0; CFG_MUL = 4'd5; tick;
    CFG_WR = 1'b0;
    lat = 3;
    while (!MIX_VALID && lat < 20) begin tick; lat++; end
    chk("acc_write_latency", lat, 6);
    chk("acc_write_mix_out", int'(MIX_OUT), 90);

    // Full-scale mix: 4 * 511 * 15 = 30660 fits 16 bits but not 10.
    RESET_n = 1'b0; tick; RESET_n = 1'b1;
    for (int ch = 0; ch < 4; ch++) cfg(ch, 15, 0, 0);
    run_mix(pack4(511, 511, 511, 511), 1'b0, 0, 0, lat, res, res10);
    chk("fullscale_latency", lat, 6);
    chk("fullscale_valid_w10", int'(MIX_VALID10), 1);
    chk("fullscale_mix_out16", res, 30660);
`ifdef SOUND_MIXER_SAT_EN
    chk("fullscale_mix_out10", res10, 511);
`else
    chk("fullscale_mix_out10", res10, -60);
`endif

    // Reset mid-ACC aborts the mix and returns gains to unity.
    SAMPLE_IN = pack4(100, -50, 20, 0); SAMPLE_STB = 1'b1; tick;
    SAMPLE_STB = 1'b0; tick;
    RESET_n = 1'b0; tick;
    RESET_n = 1'b1;
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      if (MIX_VALID) nv++;
      tick;
    end
    chk("abort_valid_count", nv, 0);
    chk("abort_mix_out", int'(MIX_OUT), 0);
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_overrun", int'(OVERRUN), 0);
    chk("abort_busy_w10", int'(BUSY10), 0);
    chk("abort_overrun_w10", int'(OVERRUN10), 0);
    run_mix(pack4(100, -50, 20, 0), 1'b0, 0, 0, lat, res, res10);
    chk("post_reset_latency", lat, 6);
    chk("post_reset_unity_gain", res, 70);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
